// File: rtl/rs_pkg.sv
// rs_pkg: GF(2^6) arithmetic, FSM encoding and Reed-Solomon generator coefficients
package rs_pkg;
  localparam int SW = 6;
  localparam logic [6:0] GF_POLY = 7'h73;
  typedef logic [SW-1:0] sym_t;
  typedef logic [15:0][SW-1:0] coef_t;
  typedef enum logic [1:0] {IDLE, MSG, PAR} state_t;
  // Carry-less 6x6 product folded back into six bits with x^6 = x^5+x^4+x+1
  function automatic sym_t gf_mul(sym_t a, sym_t b);
    logic [2*SW-2:0] p;
    p = '0;
    for (int i = 0; i < SW; i++)
      if (b[i]) p ^= {{(SW-1){1'b0}}, a} << i;
    for (int i = 2*SW-2; i >= SW; i--)
      if (p[i]) p ^= {{(SW-2){1'b0}}, GF_POLY} << (i-SW);
    return p[SW-1:0];
  endfunction
  // Expands prod(x + alpha^i), i = 0..npar-1; the monic top term is implied and not returned
  function automatic coef_t rs_gen_coef(int npar);
    logic [16:0][SW-1:0] g;
    sym_t root;
    g = '0;
    g[0] = sym_t'(1);
    root = sym_t'(1);
    for (int i = 0; i < npar; i++) begin
      for (int j = i + 1; j > 0; j--) g[j] = g[j-1] ^ gf_mul(root, g[j]);
      g[0] = gf_mul(root, g[0]);
      root = gf_mul(root, sym_t'(2));
    end
    return g[15:0];
  endfunction
  // Generator taps for the supported parity counts 2, 8 and 16, folded at elaboration
  localparam coef_t RS_GEN_COEF [3] = '{rs_gen_coef(2), rs_gen_coef(8), rs_gen_coef(16)};
endpackage

// File: rtl/gf64_const_mult.sv
// gf64_const_mult: multiply a GF(2^6) symbol by a constant, reducing to an XOR tree
module gf64_const_mult import rs_pkg::*; #(
  parameter logic [5:0] C = 6'h00
) (
  input  logic [5:0] a,
  output logic [5:0] y
);
  // Each set bit of a adds the constant product C*alpha^bit
  always_comb begin
    y = '0;
    for (int i = 0; i < SW; i++)
      if (a[i]) y ^= gf_mul(C, sym_t'(1) << i);
  end
endmodule

// File: rtl/rs_encode.sv
// rs_encode: systematic RS(N, N-NPAR) encoder over GF(2^6) with valid/ready streaming
module rs_encode import rs_pkg::*; #(
  parameter int N = 63,
  parameter int NPAR = 8,
  parameter int SW = 6
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sop,
  input  logic [SW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sop,
  output logic          out_eop,
  output logic [SW-1:0] out_data,
  output logic          sop_err
);
  localparam coef_t G = NPAR == 2 ? RS_GEN_COEF[0] : NPAR == 8 ? RS_GEN_COEF[1] :
                        NPAR == 16 ? RS_GEN_COEF[2] : rs_gen_coef(NPAR);
  localparam logic [5:0] K_CNT = 6'(N - NPAR);
  localparam logic [5:0] P_LAST = 6'(NPAR - 1);
  state_t state;
  logic [NPAR-1:0][SW-1:0] r, base, prod, nxt;
  logic [SW-1:0] fb;
  logic [5:0] msg_cnt, par_cnt, cnt_nxt;
  logic free, acc;
  assign free = !out_valid || out_ready;
  assign in_ready = RESET && free && state != PAR;
  assign acc = in_valid && in_ready;
  // A start-of-frame symbol sees cleared parity registers
  assign base = state == IDLE ? '0 : r;
  assign fb = in_data ^ base[NPAR-1];
  assign cnt_nxt = state == IDLE ? 6'd1 : msg_cnt + 6'd1;
  for (genvar i = 0; i < NPAR; i++) begin : g_tap
    gf64_const_mult #(.C(G[i])) u_mul (.a(fb), .y(prod[i]));
    if (i == 0) begin : g_lo
      assign nxt[i] = prod[i];
    end else begin : g_hi
      assign nxt[i] = base[i-1] ^ prod[i];
    end
  end
  // Frame FSM: encode message symbols through the LFSR, then shift parity out
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
      r <= '0;
      msg_cnt <= '0;
      par_cnt <= '0;
      out_valid <= 1'b0;
      out_sop <= 1'b0;
      out_eop <= 1'b0;
      out_data <= '0;
      sop_err <= 1'b0;
    end else begin
      sop_err <= 1'b0;
      if (free) out_valid <= 1'b0;
      case (state)
        IDLE, MSG: begin
          if (acc && (state == MSG || in_sop)) begin
            r <= nxt;
            out_valid <= 1'b1;
            out_data <= in_data;
            out_sop <= state == IDLE;
            out_eop <= 1'b0;
            msg_cnt <= cnt_nxt;
            par_cnt <= '0;
            sop_err <= state == MSG && in_sop;
            state <= cnt_nxt == K_CNT ? PAR : MSG;
          end else if (acc) begin
            sop_err <= 1'b1;
          end
        end
        default: begin
          if (free) begin
            out_valid <= 1'b1;
            out_data <= r[NPAR-1];
            out_sop <= 1'b0;
            out_eop <= par_cnt == P_LAST;
            r <= {r[NPAR-2:0], {SW{1'b0}}};
            par_cnt <= par_cnt + 6'd1;
            state <= par_cnt == P_LAST ? IDLE : PAR;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rs_encode.sv
// tb_rs_encode: randomized stream test of rs_encode against a polynomial-division model
module tb_rs_encode;
  localparam int N = 63;
  localparam int NPAR = 8;
  localparam int K = N - NPAR;

  typedef struct packed {logic par; logic sop; logic eop; logic [5:0] d;} item_t;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  logic in_valid = 1'b0, in_sop = 1'b0, out_ready = 1'b1;
  logic [5:0] in_data = '0;
  logic in_ready, out_valid, out_sop, out_eop, sop_err;
  logic [5:0] out_data;
  logic in_valid2 = 1'b0, in_sop2 = 1'b0, out_ready2 = 1'b1;
  logic [5:0] in_data2 = '0;
  logic in_ready2, out_valid2, out_sop2, out_eop2, sop_err2;
  logic [5:0] out_data2;

  int checks = 0, failures = 0, orp = 100;
  int ex[63];
  int lg[64];
  logic [5:0] gtmp[17];
  logic [5:0] gfull[NPAR+1];
  item_t exp_q[$];
  logic [5:0] msg[$];
  bit in_frame = 0, err_pend = 0;
  int err_cnt = 0, ov_cnt = 0, cw_len = 0;
  logic [5:0] cw[64];
  logic [5:0] c2[64];
  int n2 = 0, sop_pos2 = -1, eop_pos2 = -1, e2 = 0;

  rs_encode #(.N(N), .NPAR(NPAR), .SW(6)) dut (
    .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop),
    .out_eop(out_eop), .out_data(out_data), .sop_err(sop_err));

  rs_encode #(.N(N), .NPAR(2), .SW(6)) dut2 (
    .CLK(CLK), .RESET(RESET), .in_valid(in_valid2), .in_ready(in_ready2), .in_sop(in_sop2),
    .in_data(in_data2), .out_valid(out_valid2), .out_ready(out_ready2), .out_sop(out_sop2),
    .out_eop(out_eop2), .out_data(out_data2), .sop_err(sop_err2));

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    #1 out_ready = ($urandom_range(0, 99) < orp);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, req);
    end
  endtask

  function automatic logic [5:0] gm(logic [5:0] a, logic [5:0] b);
    return (a == 0 || b == 0) ? 6'd0 : 6'(ex[(lg[a] + lg[b]) % 63]);
  endfunction

  function automatic void mkgen(int np);
    for (int j = 0; j < 17; j++) gtmp[j] = '0;
    gtmp[0] = 6'd1;
    for (int i = 0; i < np; i++) begin
      for (int j = i + 1; j > 0; j--) gtmp[j] = gtmp[j-1] ^ gm(gtmp[j], 6'(ex[i]));
      gtmp[0] = gm(gtmp[0], 6'(ex[i]));
    end
  endfunction

  // Remainder of m(x)*x^NPAR divided by g(x), by schoolbook long division
  function automatic void finish_frame();
    logic [5:0] c[N];
    logic [5:0] q;
    for (int i = 0; i < N; i++) c[i] = '0;
    for (int k = 0; k < K; k++) c[N-1-k] = msg[k];
    for (int deg = N - 1; deg >= NPAR; deg--) begin
      q = c[deg];
      for (int j = 0; j <= NPAR; j++) c[deg-NPAR+j] ^= gm(q, gfull[j]);
    end
    for (int j = NPAR - 1; j >= 0; j--) exp_q.push_back(item_t'{1'b1, 1'b0, j == 0, c[j]});
    in_frame = 0;
  endfunction

  function automatic void accept(logic s, logic [5:0] d);
    if (!in_frame) begin
      if (s) begin
        msg.delete();
        msg.push_back(d);
        exp_q.push_back(item_t'{1'b0, 1'b1, 1'b0, d});
        in_frame = 1;
      end else err_pend = 1;
    end else begin
      if (s) err_pend = 1;
      msg.push_back(d);
      exp_q.push_back(item_t'{1'b0, 1'b0, 1'b0, d});
      if (msg.size() == K) finish_frame();
    end
  endfunction

  task automatic sample();
    int unl;
    bit in_par;
    item_t e;
    logic [5:0] s, s_or;
    if (!RESET) begin
      chk("reset_outputs", {out_valid, out_sop, out_eop, sop_err, in_ready, out_data}, 0);
      exp_q.delete();
      msg.delete();
      in_frame = 0;
      err_pend = 0;
      cw_len = 0;
    end else begin
      unl = exp_q.size() - int'(out_valid);
      in_par = unl > 0 && exp_q[$].par;
      chk("in_ready", in_ready, (!out_valid || out_ready) && !in_par);
      chk("sop_err", sop_err, err_pend);
      err_pend = 0;
      if (sop_err) err_cnt++;
      if (out_valid) ov_cnt++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_output", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("out_sym", {out_sop, out_eop, out_data}, {e.sop, e.eop, e.d});
        end
        if (out_sop) cw_len = 0;
        if (cw_len < 64) cw[cw_len] = out_data;
        cw_len++;
        if (out_eop) begin
          s_or = '0;
          for (int i = 0; i < NPAR; i++) begin
            s = '0;
            for (int k = 0; k < cw_len && k < 64; k++) s = gm(s, 6'(ex[i])) ^ cw[k];
            s_or |= s;
          end
          chk("syndromes", s_or, 0);
          chk("cw_len", cw_len, N);
        end
      end
      if (in_valid && in_ready) accept(in_sop, in_data);
    end
  endtask

  initial forever begin
    @(posedge CLK);
    #9 sample();
  end

  initial forever begin
    @(posedge CLK);
    #9;
    if (RESET && out_valid2 && out_ready2) begin
      if (n2 < 64) c2[n2] = out_data2;
      if (out_sop2) sop_pos2 = n2;
      if (out_eop2) eop_pos2 = n2;
      n2++;
    end
    if (sop_err2) e2++;
  end

  task automatic send(input logic s, input logic [5:0] d, input int pv);
    int w = 0;
    bit done = 0;
    while (!done) begin
      in_valid = ($urandom_range(0, 99) < pv);
      in_sop = s;
      in_data = d;
      #8 done = in_valid && in_ready;
      @(posedge CLK);
      #1;
      if (++w > 5000) begin
        failures++;
        $display("FAIL send_timeout actual=%0d cycles expected=accept", w);
        $fatal(1, "stuck input");
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 5000) begin
      @(posedge CLK);
      #1;
      w++;
    end
    chk("drain_done", w < 5000, 1);
    idle(1);
  endtask

  initial begin
    int e0, ov0, e = 1;
    logic [5:0] acc_or;
    for (int i = 0; i < 63; i++) begin
      ex[i] = e;
      lg[e] = i;
      e = e << 1;
      if (e & 64) e ^= 'h73;
    end
    chk("gm_x6", gm(6'h20, 6'h02), 6'h33);
    chk("gm_3x3", gm(6'h03, 6'h03), 6'h05);
    chk("gm_wrap", gm(6'(ex[62]), 6'h02), 6'h01);
    mkgen(2);
    chk("gen2_c1", gtmp[1], 6'h03);
    chk("gen2_c0", gtmp[0], 6'h02);
    mkgen(NPAR);
    for (int j = 0; j <= NPAR; j++) gfull[j] = gtmp[j];

    repeat (3) @(posedge CLK);
    #1 chk("in_ready_in_reset", in_ready, 0);
    RESET = 1'b1;
    #1 chk("in_ready_after_reset", in_ready, 1);
    chk("in_ready2_after_reset", in_ready2, 1);
    idle(1);
    ov0 = ov_cnt;
    idle(20);
    chk("idle_no_valid", ov_cnt - ov0, 0);

    for (int k = 0; k < 61; ) begin
      in_valid2 = 1'b1;
      in_sop2 = (k == 0);
      in_data2 = (k == 60) ? 6'h01 : 6'h00;
      #8 if (in_ready2) k++;
      @(posedge CLK);
      #1;
    end
    in_valid2 = 1'b0;
    idle(6);
    acc_or = '0;
    for (int k = 0; k < 60; k++) acc_or |= c2[k];
    chk("npar2_len", n2, 63);
    chk("npar2_msg_zero", acc_or, 0);
    chk("npar2_last_msg", c2[60], 6'h01);
    chk("npar2_par0", c2[61], 6'h03);
    chk("npar2_par1", c2[62], 6'h02);
    chk("npar2_sop_pos", sop_pos2, 0);
    chk("npar2_eop_pos", eop_pos2, 62);
    chk("npar2_no_sop_err", e2, 0);

    for (int k = 0; k < K; k++) send(k == 0, 6'h00, 100);
    drain();
    acc_or = '0;
    for (int k = 0; k < N; k++) acc_or |= cw[k];
    chk("zero_frame_len", cw_len, N);
    chk("zero_frame_data", acc_or, 0);

    e0 = err_cnt;
    for (int k = 0; k < K; k++) send(k == 0 || k == 10, 6'($urandom_range(0, 63)), 100);
    drain();
    chk("mid_sop_err_pulses", err_cnt - e0, 1);
    chk("mid_sop_frame_len", cw_len, N);

    e0 = err_cnt;
    ov0 = ov_cnt;
    send(1'b0, 6'h15, 100);
    idle(3);
    chk("idle_stray_err", err_cnt - e0, 1);
    chk("idle_stray_dropped", ov_cnt - ov0, 0);

    for (int k = 0; k < K; k++) send(k == 0, 6'($urandom_range(0, 63)), 100);
    repeat (3) @(posedge CLK);
    #2 chk("third_parity_valid", {out_valid, out_eop}, 2'b10);
    RESET = 1'b0;
    #1 chk("mid_reset_outputs", {out_valid, in_ready, out_data}, 0);
    @(posedge CLK);
    #1 RESET = 1'b1;
    for (int k = 0; k < K; k++) send(k == 0, 6'($urandom_range(0, 63)), 100);
    drain();
    chk("post_reset_frame_len", cw_len, N);

    orp = 50;
    for (int f = 0; f < 200; f++) begin
      for (int k = 0; k < K; k++) send(k == 0, 6'($urandom_range(0, 63)), 70);
      idle($urandom_range(0, 2));
    end
    drain();
    orp = 100;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
